// File: rtl/tdc_word_decoder_if.sv
// FIFO-side and output-side signal bundle for the TDC word decoder.
interface tdc_word_decoder_if;
   // Source FIFO (first-word-fall-through)
   logic        FIFO_EMPTY;
   logic [31:0] FIFO_DATA;
   logic        FIFO_READ;
   // Decoded output stream
   logic [11:0] EVENT_CNT;
   logic [15:0] TDC_VALUE;
   logic        OUT_VALID;
   logic        OUT_READY;
   logic        SEQ_ERR;

   // Decoder side
   modport master (
      input  FIFO_EMPTY,
      input  FIFO_DATA,
      input  OUT_READY,
      output FIFO_READ,
      output EVENT_CNT,
      output TDC_VALUE,
      output OUT_VALID,
      output SEQ_ERR
   );

   // FIFO owner / output consumer side
   modport slave (
      output FIFO_EMPTY,
      output FIFO_DATA,
      output OUT_READY,
      input  FIFO_READ,
      input  EVENT_CNT,
      input  TDC_VALUE,
      input  OUT_VALID,
      input  SEQ_ERR
   );
endinterface

// File: rtl/tdc_word_decoder.sv
// Pops TDC words from a FWFT FIFO, filters on the identifier nibble, checks
// event-counter continuity and presents decoded words on a valid/ready port.
module tdc_word_decoder #(
   parameter logic [3:0] DATA_IDENTIFIER = 4'b0100
) (
   input  logic                BUS_CLK,
   input  logic                BUS_RST,
   input  logic                ENABLE,
   input  logic                CLEAR,
   tdc_word_decoder_if.master  bus,
   output logic [7:0]          ID_ERR_CNT,
   output logic [7:0]          SEQ_ERR_CNT,
   output logic [31:0]         WORD_CNT
);

   localparam int unsigned EVT_W  = 12;
   localparam int unsigned TDC_W  = 16;
   localparam int unsigned ERR_W  = 8;
   localparam int unsigned WORD_W = 32;

   typedef enum logic {
      SYNC   = 1'b0,
      LOCKED = 1'b1
   } state_e;

   state_e             state_q, state_d;
   logic [EVT_W-1:0]   last_q, last_d;
   logic [EVT_W-1:0]   event_cnt_q, event_cnt_d;
   logic [TDC_W-1:0]   tdc_value_q, tdc_value_d;
   logic               out_valid_q, out_valid_d;
   logic               seq_err_q, seq_err_d;
   logic [ERR_W-1:0]   id_err_cnt_q, id_err_cnt_d;
   logic [ERR_W-1:0]   seq_err_cnt_q, seq_err_cnt_d;
   logic [WORD_W-1:0]  word_cnt_q, word_cnt_d;

   logic               fifo_read_c;
   logic               id_match_c;
   logic [EVT_W-1:0]   head_evt_c;
   logic [TDC_W-1:0]   head_tdc_c;
   logic [EVT_W-1:0]   expect_evt_c;

   // Pop when enabled, not clearing, data present and the output slot frees up;
   // forced low while reset is held.
   assign fifo_read_c = ENABLE & ~CLEAR & ~bus.FIFO_EMPTY & ~BUS_RST &
                        (~out_valid_q | bus.OUT_READY);

   assign id_match_c   = (bus.FIFO_DATA[31:28] == DATA_IDENTIFIER);
   assign head_evt_c   = bus.FIFO_DATA[27:16];
   assign head_tdc_c   = bus.FIFO_DATA[15:0];
   assign expect_evt_c = last_q + EVT_W'(1);

   // Next-state: clear, ID filtering, sequence check and output handshake
   always_comb begin
      state_d       = state_q;
      last_d        = last_q;
      event_cnt_d   = event_cnt_q;
      tdc_value_d   = tdc_value_q;
      out_valid_d   = out_valid_q;
      seq_err_d     = 1'b0;
      id_err_cnt_d  = id_err_cnt_q;
      seq_err_cnt_d = seq_err_cnt_q;
      word_cnt_d    = word_cnt_q;

      // A transfer this cycle frees the slot unless refilled below
      if (out_valid_q && bus.OUT_READY) begin
         out_valid_d = 1'b0;
      end

      if (CLEAR) begin
         state_d       = SYNC;
         last_d        = '0;
         event_cnt_d   = '0;
         tdc_value_d   = '0;
         out_valid_d   = 1'b0;
         id_err_cnt_d  = '0;
         seq_err_cnt_d = '0;
         word_cnt_d    = '0;
      end else if (fifo_read_c) begin
         if (id_match_c) begin
            event_cnt_d = head_evt_c;
            tdc_value_d = head_tdc_c;
            out_valid_d = 1'b1;
            word_cnt_d  = word_cnt_q + WORD_W'(1);
            last_d      = head_evt_c;
            state_d     = LOCKED;
            // First word after SYNC only seeds the reference count
            if ((state_q == LOCKED) && (head_evt_c != expect_evt_c)) begin
               seq_err_d = 1'b1;
               if (seq_err_cnt_q != '1) begin
                  seq_err_cnt_d = seq_err_cnt_q + ERR_W'(1);
               end
            end
         end else begin
            if (id_err_cnt_q != '1) begin
               id_err_cnt_d = id_err_cnt_q + ERR_W'(1);
            end
         end
      end
   end

   // State and output registers
   always_ff @(posedge BUS_CLK or posedge BUS_RST) begin
      if (BUS_RST) begin
         state_q       <= SYNC;
         last_q        <= '0;
         event_cnt_q   <= '0;
         tdc_value_q   <= '0;
         out_valid_q   <= 1'b0;
         seq_err_q     <= 1'b0;
         id_err_cnt_q  <= '0;
         seq_err_cnt_q <= '0;
         word_cnt_q    <= '0;
      end else begin
         state_q       <= state_d;
         last_q        <= last_d;
         event_cnt_q   <= event_cnt_d;
         tdc_value_q   <= tdc_value_d;
         out_valid_q   <= out_valid_d;
         seq_err_q     <= seq_err_d;
         id_err_cnt_q  <= id_err_cnt_d;
         seq_err_cnt_q <= seq_err_cnt_d;
         word_cnt_q    <= word_cnt_d;
      end
   end

   assign bus.FIFO_READ = fifo_read_c;
   assign bus.EVENT_CNT = event_cnt_q;
   assign bus.TDC_VALUE = tdc_value_q;
   assign bus.OUT_VALID = out_valid_q;
   assign bus.SEQ_ERR   = seq_err_q;
   assign ID_ERR_CNT    = id_err_cnt_q;
   assign SEQ_ERR_CNT   = seq_err_cnt_q;
   assign WORD_CNT      = word_cnt_q;

endmodule

// File: tb/tb_tdc_word_decoder.sv
// Directed bench for tdc_word_decoder with a behavioural FWFT FIFO.
module tb_tdc_word_decoder;

   logic        clk;
   logic        rst;
   logic        enable;
   logic        clear;
   logic [7:0]  id_err_cnt;
   logic [7:0]  seq_err_cnt;
   logic [31:0] word_cnt;

   int total;
   int bad;
   int pops;
   int seq_seen;

   logic [31:0] fq[$];
   logic [27:0] got[$];

   tdc_word_decoder_if bus ();

   tdc_word_decoder dut (
      .BUS_CLK     (clk),
      .BUS_RST     (rst),
      .ENABLE      (enable),
      .CLEAR       (clear),
      .bus         (bus),
      .ID_ERR_CNT  (id_err_cnt),
      .SEQ_ERR_CNT (seq_err_cnt),
      .WORD_CNT    (word_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic fifo_refresh();
      bus.FIFO_EMPTY = (fq.size() == 0);
      bus.FIFO_DATA  = (fq.size() == 0) ? 32'h0 : fq[0];
   endtask

   task automatic push(input logic [31:0] w);
      fq.push_back(w);
      fifo_refresh();
   endtask

   // One clock: sample handshake at negedge, apply pop/transfer at posedge, return at posedge+1
   task automatic tick();
      logic        rd;
      logic        xf;
      logic [27:0] ow;
      @(negedge clk);
      rd = bus.FIFO_READ;
      xf = bus.OUT_VALID & bus.OUT_READY;
      ow = {bus.EVENT_CNT, bus.TDC_VALUE};
      @(posedge clk);
      if (rd && fq.size() != 0) begin
         void'(fq.pop_front());
         pops++;
      end
      if (xf) got.push_back(ow);
      #1;
      fifo_refresh();
      if (bus.SEQ_ERR === 1'b1) seq_seen++;
   endtask

   task automatic test_reset();
      rst = 1'b1; enable = 1'b0; clear = 1'b0; bus.OUT_READY = 1'b0;
      fifo_refresh();
      tick(); tick();
      total++; if (bus.OUT_VALID !== 1'b0) begin bad++; $display("FAIL rst_valid: got %0b want 0", bus.OUT_VALID); end
      total++; if (bus.EVENT_CNT !== 12'h0) begin bad++; $display("FAIL rst_event: got %h want 000", bus.EVENT_CNT); end
      total++; if (bus.TDC_VALUE !== 16'h0) begin bad++; $display("FAIL rst_tdc: got %h want 0000", bus.TDC_VALUE); end
      total++; if (bus.SEQ_ERR !== 1'b0) begin bad++; $display("FAIL rst_seqerr: got %0b want 0", bus.SEQ_ERR); end
      total++; if ({id_err_cnt, seq_err_cnt, word_cnt} !== 48'h0) begin bad++; $display("FAIL rst_counters: got %h %h %h want 0 0 0", id_err_cnt, seq_err_cnt, word_cnt); end
      total++; if (bus.FIFO_READ !== 1'b0) begin bad++; $display("FAIL rst_read: got %0b want 0", bus.FIFO_READ); end
      rst = 1'b0;
      tick();
   endtask

   task automatic test_basic();
      seq_seen = 0;
      enable = 1'b1; bus.OUT_READY = 1'b1;
      push(32'h4001_0123); push(32'h4002_0456);
      tick();
      total++; if ({bus.OUT_VALID, bus.EVENT_CNT, bus.TDC_VALUE} !== {1'b1, 12'h001, 16'h0123}) begin bad++; $display("FAIL basic_w1: got v=%0b e=%h t=%h want v=1 e=001 t=0123", bus.OUT_VALID, bus.EVENT_CNT, bus.TDC_VALUE); end
      tick();
      total++; if ({bus.OUT_VALID, bus.EVENT_CNT, bus.TDC_VALUE} !== {1'b1, 12'h002, 16'h0456}) begin bad++; $display("FAIL basic_w2: got v=%0b e=%h t=%h want v=1 e=002 t=0456", bus.OUT_VALID, bus.EVENT_CNT, bus.TDC_VALUE); end
      tick();
      total++; if (bus.OUT_VALID !== 1'b0) begin bad++; $display("FAIL basic_drain: got %0b want 0", bus.OUT_VALID); end
      total++; if (word_cnt !== 32'd2) begin bad++; $display("FAIL basic_wordcnt: got %0d want 2", word_cnt); end
      total++; if (seq_seen !== 0) begin bad++; $display("FAIL basic_seqerr: got %0d pulses want 0", seq_seen); end
   endtask

   task automatic test_bad_id();
      push(32'h3005_0001);
      #1;
      total++; if (bus.FIFO_READ !== 1'b1) begin bad++; $display("FAIL badid_read: got %0b want 1", bus.FIFO_READ); end
      tick();
      total++; if (fq.size() !== 0) begin bad++; $display("FAIL badid_popped: got %0d left want 0", fq.size()); end
      total++; if (id_err_cnt !== 8'd1) begin bad++; $display("FAIL badid_cnt: got %0d want 1", id_err_cnt); end
      total++; if (bus.OUT_VALID !== 1'b0) begin bad++; $display("FAIL badid_valid: got %0b want 0", bus.OUT_VALID); end
      tick();
      total++; if (bus.OUT_VALID !== 1'b0) begin bad++; $display("FAIL badid_valid2: got %0b want 0", bus.OUT_VALID); end
   endtask

   task automatic test_wrap();
      clear = 1'b1;
      tick();
      clear = 1'b0;
      total++; if ({id_err_cnt, seq_err_cnt, word_cnt} !== 48'h0) begin bad++; $display("FAIL wrap_clear: got %h %h %h want 0 0 0", id_err_cnt, seq_err_cnt, word_cnt); end
      seq_seen = 0;
      push(32'h4FFF_0000); push(32'h4000_0001); push(32'h4005_0002);
      tick();
      total++; if ({bus.SEQ_ERR, bus.EVENT_CNT} !== {1'b0, 12'hFFF}) begin bad++; $display("FAIL wrap_fff: got s=%0b e=%h want s=0 e=fff", bus.SEQ_ERR, bus.EVENT_CNT); end
      tick();
      total++; if ({bus.SEQ_ERR, bus.EVENT_CNT} !== {1'b0, 12'h000}) begin bad++; $display("FAIL wrap_000: got s=%0b e=%h want s=0 e=000", bus.SEQ_ERR, bus.EVENT_CNT); end
      tick();
      total++; if ({bus.SEQ_ERR, bus.OUT_VALID, bus.EVENT_CNT} !== {1'b1, 1'b1, 12'h005}) begin bad++; $display("FAIL wrap_005: got s=%0b v=%0b e=%h want s=1 v=1 e=005", bus.SEQ_ERR, bus.OUT_VALID, bus.EVENT_CNT); end
      tick();
      total++; if (bus.SEQ_ERR !== 1'b0) begin bad++; $display("FAIL wrap_pulse: got %0b want 0", bus.SEQ_ERR); end
      total++; if (seq_seen !== 1) begin bad++; $display("FAIL wrap_pulses: got %0d want 1", seq_seen); end
      total++; if (seq_err_cnt !== 8'd1) begin bad++; $display("FAIL wrap_seqcnt: got %0d want 1", seq_err_cnt); end
   endtask

   task automatic test_backpressure();
      got.delete();
      pops = 0;
      bus.OUT_READY = 1'b0;
      push(32'h4006_0010); push(32'h4007_0020); push(32'h4008_0030);
      for (int i = 0; i < 5; i++) begin
         tick();
         total++; if ({bus.OUT_VALID, bus.EVENT_CNT, bus.TDC_VALUE} !== {1'b1, 12'h006, 16'h0010}) begin bad++; $display("FAIL bp_hold%0d: got v=%0b e=%h t=%h want v=1 e=006 t=0010", i, bus.OUT_VALID, bus.EVENT_CNT, bus.TDC_VALUE); end
      end
      total++; if (pops !== 1) begin bad++; $display("FAIL bp_pops: got %0d want 1", pops); end
      total++; if (fq.size() !== 2) begin bad++; $display("FAIL bp_queued: got %0d want 2", fq.size()); end
      bus.OUT_READY = 1'b1;
      tick(); tick(); tick();
      total++; if (got.size() !== 3) begin bad++; $display("FAIL bp_count: got %0d want 3", got.size()); end
      else begin
         total++; if (got[0] !== 28'h006_0010) begin bad++; $display("FAIL bp_out0: got %h want 0060010", got[0]); end
         total++; if (got[1] !== 28'h007_0020) begin bad++; $display("FAIL bp_out1: got %h want 0070020", got[1]); end
         total++; if (got[2] !== 28'h008_0030) begin bad++; $display("FAIL bp_out2: got %h want 0080030", got[2]); end
      end
      total++; if (bus.OUT_VALID !== 1'b0) begin bad++; $display("FAIL bp_drain: got %0b want 0", bus.OUT_VALID); end
      total++; if (word_cnt !== 32'd6) begin bad++; $display("FAIL bp_wordcnt: got %0d want 6", word_cnt); end
   endtask

   task automatic test_sat_clear();
      int n;
      for (int i = 0; i < 300; i++) push(32'h3000_0000 | 32'(i));
      n = 0;
      while (fq.size() != 0 && n < 400) begin
         tick();
         n++;
      end
      total++; if (fq.size() !== 0) begin bad++; $display("FAIL sat_timeout: got %0d left want 0", fq.size()); end
      total++; if (id_err_cnt !== 8'd255) begin bad++; $display("FAIL sat_idcnt: got %0d want 255", id_err_cnt); end
      clear = 1'b1;
      tick();
      clear = 1'b0;
      total++; if ({id_err_cnt, seq_err_cnt, word_cnt} !== 48'h0) begin bad++; $display("FAIL sat_clear: got %h %h %h want 0 0 0", id_err_cnt, seq_err_cnt, word_cnt); end
      total++; if (bus.OUT_VALID !== 1'b0) begin bad++; $display("FAIL sat_clear_valid: got %0b want 0", bus.OUT_VALID); end
      seq_seen = 0;
      push(32'h4020_0000);
      tick();
      total++; if ({bus.OUT_VALID, bus.SEQ_ERR, bus.EVENT_CNT} !== {1'b1, 1'b0, 12'h020}) begin bad++; $display("FAIL sat_sync: got v=%0b s=%0b e=%h want v=1 s=0 e=020", bus.OUT_VALID, bus.SEQ_ERR, bus.EVENT_CNT); end
      tick();
      total++; if (seq_seen !== 0 || seq_err_cnt !== 8'd0) begin bad++; $display("FAIL sat_noseq: got pulses=%0d cnt=%0d want 0 0", seq_seen, seq_err_cnt); end
      total++; if (word_cnt !== 32'd1) begin bad++; $display("FAIL sat_wordcnt: got %0d want 1", word_cnt); end
   endtask

   task automatic test_reset_mid();
      bus.OUT_READY = 1'b0;
      push(32'h4021_0001);
      tick();
      total++; if ({bus.OUT_VALID, bus.EVENT_CNT} !== {1'b1, 12'h021}) begin bad++; $display("FAIL rm_pending: got v=%0b e=%h want v=1 e=021", bus.OUT_VALID, bus.EVENT_CNT); end
      push(32'h4022_0002);
      #1;
      total++; if (bus.FIFO_READ !== 1'b0) begin bad++; $display("FAIL rm_stalled: got %0b want 0", bus.FIFO_READ); end
      rst = 1'b1;
      #1;
      total++; if (bus.OUT_VALID !== 1'b0) begin bad++; $display("FAIL rm_async_valid: got %0b want 0", bus.OUT_VALID); end
      total++; if ({bus.EVENT_CNT, word_cnt} !== 44'h0) begin bad++; $display("FAIL rm_async_regs: got e=%h w=%0d want 0 0", bus.EVENT_CNT, word_cnt); end
      bus.OUT_READY = 1'b1;
      #1;
      total++; if (bus.FIFO_READ !== 1'b0) begin bad++; $display("FAIL rm_read_in_rst: got %0b want 0", bus.FIFO_READ); end
      tick();
      total++; if (fq.size() !== 1) begin bad++; $display("FAIL rm_nopop: got %0d left want 1", fq.size()); end
      seq_seen = 0;
      rst = 1'b0;
      tick();
      total++; if (fq.size() !== 0) begin bad++; $display("FAIL rm_pop_after: got %0d left want 0", fq.size()); end
      total++; if ({bus.OUT_VALID, bus.EVENT_CNT, bus.TDC_VALUE} !== {1'b1, 12'h022, 16'h0002}) begin bad++; $display("FAIL rm_word: got v=%0b e=%h t=%h want v=1 e=022 t=0002", bus.OUT_VALID, bus.EVENT_CNT, bus.TDC_VALUE); end
      total++; if (seq_seen !== 0 || word_cnt !== 32'd1) begin bad++; $display("FAIL rm_state: got pulses=%0d w=%0d want 0 1", seq_seen, word_cnt); end
   endtask

   initial begin
      total = 0; bad = 0; pops = 0; seq_seen = 0;
      test_reset();
      test_basic();
      test_bad_id();
      test_wrap();
      test_backpressure();
      test_sat_clear();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/tdc_word_decoder.md
TDC_WORD_DECODER -- requirements
Module: tdc_word_decoder

Interface
REQ-001 SHALL have parameter DATA_IDENTIFIER, default 4'b0100, the word identifier accepted in FIFO_DATA[31:28].
REQ-002 SHALL have port BUS_CLK, input, 1 bit: the single clock; all logic rising-edge on BUS_CLK.
REQ-003 SHALL have port BUS_RST, input, 1 bit: reset, asynchronous, active-high.
REQ-004 SHALL have port ENABLE, input, 1 bit: permits popping the FIFO.
REQ-005 SHALL have port CLEAR, input, 1 bit: synchronous clear of counters, state and output word.
REQ-006 SHALL have port FIFO_EMPTY, input, 1 bit: source FIFO empty; first-word-fall-through.
REQ-007 SHALL have port FIFO_DATA, input, 32 bits: head word of the source FIFO, valid while FIFO_EMPTY=0.
REQ-008 SHALL have port FIFO_READ, output, 1 bit: pops the head word in the cycle it is high.
REQ-009 SHALL have port EVENT_CNT, output, 12 bits: decoded FIFO_DATA[27:16].
REQ-010 SHALL have port TDC_VALUE, output, 16 bits: decoded FIFO_DATA[15:0].
REQ-011 SHALL have ports OUT_VALID (output, 1 bit) and OUT_READY (input, 1 bit): output handshake.
REQ-012 SHALL have port SEQ_ERR, output, 1 bit: one-cycle pulse on an event-counter discontinuity.
REQ-013 SHALL have ports ID_ERR_CNT (output, 8 bits), SEQ_ERR_CNT (output, 8 bits) and WORD_CNT (output, 32 bits): statistics.

Function
REQ-014 SHALL drive FIFO_READ = ENABLE & !CLEAR & !FIFO_EMPTY & (!OUT_VALID | OUT_READY), combinationally.
REQ-015 SHALL treat a popped word with FIFO_DATA[31:28] != DATA_IDENTIFIER as an ID error: discard it, increment ID_ERR_CNT (saturating at 255), leave the outputs and state unchanged.
REQ-016 SHALL treat a popped word with a matching identifier as good: on the next edge, load EVENT_CNT/TDC_VALUE, set OUT_VALID=1 and increment WORD_CNT (32-bit, wraps to 0) -- a latency of 1 cycle from pop to OUT_VALID.
REQ-017 SHALL complete an output transfer in a cycle with OUT_VALID=1 and OUT_READY=1; OUT_VALID falls on the next edge unless a new good word is popped in that same cycle, giving back-to-back throughput of one word per cycle.
REQ-018 SHALL hold EVENT_CNT, TDC_VALUE and OUT_VALID stable while OUT_VALID=1 and OUT_READY=0.
REQ-019 SHALL implement a two-state machine with states SYNC and LOCKED; the reset state is SYNC.
REQ-020 SHALL, in SYNC, accept the first good word without a sequence check, store its event count as LAST, and go to LOCKED.
REQ-021 SHALL, in LOCKED, compare each good word's event count with (LAST+1) mod 4096.
REQ-022 SHALL, on a mismatch in LOCKED, pulse SEQ_ERR for one cycle, aligned with OUT_VALID rising for that word, and increment SEQ_ERR_CNT (saturating at 255).
REQ-023 SHALL still forward a word with a sequence error and update LAST to that word's event count.
REQ-024 SHALL treat the wrap 4095 -> 0 as in sequence.
REQ-025 SHALL, with ENABLE=0, perform no pops; a pending output word still drains via the handshake, and the state machine state and LAST are kept.
REQ-026 SHALL give CLEAR priority over everything else: on the next edge, zero ID_ERR_CNT, SEQ_ERR_CNT and WORD_CNT, drop any pending output (OUT_VALID=0), set SEQ_ERR=0 and return the state machine to SYNC; there is no pop in a CLEAR cycle.
REQ-027 SHALL increment a saturated counter by 0; it stays at 255 until CLEAR or reset.

Reset
REQ-028 SHALL, on BUS_RST high, immediately and asynchronously set OUT_VALID=0, SEQ_ERR=0, EVENT_CNT=0, TDC_VALUE=0, all counters to 0, LAST=0 and the state to SYNC.
REQ-029 SHALL hold FIFO_READ at 0 while BUS_RST is high, even though FIFO_READ is combinational.
REQ-030 SHALL lose any pending output word when reset is asserted mid-operation; no pop occurs until the first edge after reset is released.

Verification
REQ-031 Bench SHALL cover: words 0x4001_0123, 0x4002_0456 with OUT_READY=1 -> outputs (1,0x0123) then (2,0x0456) on consecutive cycles, WORD_CNT=2, SEQ_ERR never high.
REQ-032 Bench SHALL cover: word 0x3005_0001 -> popped and dropped, ID_ERR_CNT=1, OUT_VALID stays 0.
REQ-033 Bench SHALL cover: event counts 0xFFF, 0x000, 0x005 -> no error at the wrap; SEQ_ERR pulses once on 0x005; SEQ_ERR_CNT=1.
REQ-034 Bench SHALL cover: OUT_READY=0 for 5 cycles with 3 words queued -> exactly 1 pop, outputs held, then the remaining 2 words delivered after OUT_READY=1.
REQ-035 Bench SHALL cover: 300 bad-ID words -> ID_ERR_CNT=255; then CLEAR -> all counters 0, state SYNC, so the next good word produces no SEQ_ERR.
REQ-036 Bench SHALL cover: BUS_RST asserted while OUT_VALID=1 -> OUT_VALID=0 with no clock edge; FIFO_READ=0 until the first edge after release.
